// File: rtl/flopens_pipe.sv
// Elastic pipeline register: DEPTH stages of WIDTH-bit data with per-stage valid,
// global enable, synchronous set-to-constant and flush, and valid/ready flow control.
module flopens_pipe #(
  parameter int              WIDTH  = 8,
  parameter int              DEPTH  = 2,
  parameter logic [WIDTH-1:0] SETVAL = WIDTH'(1),
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic                       set,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH:0]   rdy;
  logic             live;
  logic             xfer_in;
  logic             xfer_out;

  // A stage can take new data if it is empty or its occupant moves on, so bubbles collapse.
  always_comb begin : ready_chain
    logic r;
    rdy        = '0;
    r          = out_ready;
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r      = ~v_q[k] | r;
      rdy[k] = r;
    end
  end

  assign live      = reset_n & en & ~set & ~flush;
  assign in_ready  = live & rdy[0];
  assign out_valid = live & v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q;
    if (set) begin
      v_d     = '0;
      count_d = '0;
      for (int k = 0; k < DEPTH; k++) d_d[k] = SETVAL;
    end else if (flush) begin
      v_d     = '0;
      count_d = '0;
    end else if (en) begin
      if (rdy[0]) begin
        v_d[0] = in_valid;
        if (in_valid) d_d[0] = in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) d_d[k] = d_q[k-1];
        end
      end
      count_d = count_q + CW'(xfer_in) - CW'(xfer_out);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= RSTVAL;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_flopens_pipe.sv
// Bench for flopens_pipe (WIDTH=8, DEPTH=3): position-list reference model checked every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_flopens_pipe;
  localparam int         D      = 3;
  localparam logic [7:0] SETV   = 8'hA5;
  localparam logic [7:0] RSTV   = 8'h00;

  logic       clk, reset_n, en, set, flush, in_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic       in_ready, out_valid;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;

  flopens_pipe #(.WIDTH(8), .DEPTH(D), .SETVAL(SETV), .RSTVAL(RSTV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .set(set), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: oldest-first list of items with their stage positions.
  int         mq_pos[$];
  logic [7:0] mq_dat[$];
  logic [7:0] m_last;

  always @(negedge clk) begin : model
    int         np[$];
    int         nq_pos[$];
    logic [7:0] nq_dat[$];
    int         ahead;
    int         n;
    bit         rdy0, act;
    if (!reset_n) begin
      chk("m_rst_out_valid", out_valid, 0);
      chk("m_rst_in_ready", in_ready, 0);
      chk("m_rst_count", count, 0);
      chk("m_rst_out_data", out_data, RSTV);
      mq_pos.delete();
      mq_dat.delete();
      m_last = RSTV;
    end else begin
      np.delete();
      ahead = D;
      for (int i = 0; i < mq_pos.size(); i++) begin
        if (mq_pos[i] == D - 1 && out_ready) begin
          np.push_back(-1);
        end else begin
          n = (mq_pos[i] + 1 < ahead) ? mq_pos[i] + 1 : mq_pos[i];
          np.push_back(n);
          ahead = n;
        end
      end
      rdy0 = (ahead > 0);
      act  = en && !set && !flush;
      chk("m_in_ready", in_ready, act && rdy0);
      chk("m_out_valid", out_valid, act && mq_pos.size() > 0 && mq_pos[0] == D - 1);
      chk("m_count", count, mq_pos.size());
      chk("m_out_data", out_data, m_last);
      if (set) begin
        mq_pos.delete();
        mq_dat.delete();
        m_last = SETV;
      end else if (flush) begin
        mq_pos.delete();
        mq_dat.delete();
      end else if (en) begin
        nq_pos.delete();
        nq_dat.delete();
        for (int i = 0; i < mq_pos.size(); i++) begin
          if (np[i] >= 0) begin
            if (np[i] == D - 1 && mq_pos[i] != D - 1) m_last = mq_dat[i];
            nq_pos.push_back(np[i]);
            nq_dat.push_back(mq_dat[i]);
          end
        end
        if (in_valid && rdy0) begin
          nq_pos.push_back(0);
          nq_dat.push_back(in_data);
          if (D == 1) m_last = in_data;
        end
        mq_pos = nq_pos;
        mq_dat = nq_dat;
      end
    end
  end

  task automatic push_n(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] v[3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; set = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // 1: async reset mid-cycle
    en = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    step(); step();
    in_valid = 1'b0;
    step(); step();
    chk("t1_pre_count", count, 2);
    chk("t1_pre_out_data", out_data, 8'h77);
    chk("t1_pre_out_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_count", count, 0);
    chk("t1_out_data", out_data, 8'h00);
    chk("t1_in_ready", in_ready, 0);
    step();
    reset_n = 1'b1;
    step();

    // 2: streaming, 3-cycle latency, one per cycle
    en = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      in_valid = (c <= 5);
      in_data  = 8'(c);
      step();
      chk("t2_out_valid", out_valid, (c >= 3 && c <= 7));
      if (c >= 3 && c <= 7) chk("t2_out_data", out_data, c - 2);
    end
    in_valid = 1'b0;
    chk("t2_count_end", count, 0);

    // 3: backpressure
    out_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(c);
      #1;
      chk("t3_in_ready", in_ready, (c <= 3));
      step();
    end
    chk("t3_count_full", count, 3);
    chk("t3_in_ready_full", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_drain", in_ready, 1);
    chk("t3_out0", out_data, 8'h01);
    step();
    in_valid = 1'b0;
    chk("t3_out1", out_data, 8'h02);
    step();
    chk("t3_out2", out_data, 8'h03);
    step();
    chk("t3_out3", out_data, 8'h04);
    chk("t3_out3_valid", out_valid, 1);
    step();
    chk("t3_empty", out_valid, 0);

    // 4: bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 8'h22; step();
    in_data = 8'h33;
    #1;
    chk("t4_in_ready_33", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t4_count", count, 3);
    chk("t4_head", out_data, 8'h11);
    out_ready = 1'b1;
    step();
    chk("t4_seq1", out_data, 8'h22);
    chk("t4_seq1_valid", out_valid, 1);
    step();
    chk("t4_seq2", out_data, 8'h33);
    chk("t4_seq2_valid", out_valid, 1);
    step();
    chk("t4_empty", count, 0);

    // 5: set beats flush; flush alone keeps data
    out_ready = 1'b0;
    push_n(8'hA1, 8'hA2, 8'hA3);
    chk("t5_full", count, 3);
    chk("t5_head", out_data, 8'hA1);
    set = 1'b1; flush = 1'b1;
    #1;
    chk("t5_set_out_valid", out_valid, 0);
    chk("t5_set_in_ready", in_ready, 0);
    step();
    set = 1'b0; flush = 1'b0;
    chk("t5_set_count", count, 0);
    chk("t5_set_valid", out_valid, 0);
    chk("t5_set_data", out_data, 8'hA5);
    push_n(8'hB1, 8'hB2, 8'hB3);
    chk("t5_refill_head", out_data, 8'hB1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_flush_count", count, 0);
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_data", out_data, 8'hB1);

    // 6: enable low freezes everything
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hC1; step();
    in_data = 8'hC2; step();
    in_valid = 1'b0; step(); step();
    chk("t6_pre_count", count, 2);
    chk("t6_pre_data", out_data, 8'hC1);
    en = 1'b0; in_valid = 1'b1; in_data = 8'hDD; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6_in_ready", in_ready, 0);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_count", count, 2);
      chk("t6_data", out_data, 8'hC1);
    end
    in_valid = 1'b0;
    en = 1'b1;
    #1;
    chk("t6_resume_valid", out_valid, 1);
    chk("t6_resume_data", out_data, 8'hC1);
    step();
    chk("t6_next_data", out_data, 8'hC2);
    step(); step();
    chk("t6_drained", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
